// File: rtl/uart_rx_ctl.sv
// UART receiver: 16x oversampled 8N1 framing with mid-bit sampling.
// Define UART_RX_MAJORITY_VOTE_EN to form each sample by 3-tick majority vote.
module uart_rx_ctl (
  input  logic       clk_rx,
  input  logic       rst_clk_rx,
  input  logic       baud_x16_en,
  input  logic       rxd_clk_rx,
  output logic [7:0] rx_data,
  output logic       rx_data_rdy,
  output logic       frm_err
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t     state;
  logic [3:0] os_cnt;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       sample;
  logic       done;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [2:0] hist;

  always_ff @(posedge clk_rx or posedge rst_clk_rx) begin
    if (rst_clk_rx) begin
      hist <= 3'b111;
    end else if (baud_x16_en) begin
      hist <= {hist[1:0], rxd_clk_rx};
    end
  end

  assign sample = (rxd_clk_rx & hist[0])
                | (rxd_clk_rx & hist[1])
                | (hist[0] & hist[1]);
`else
  assign sample = rxd_clk_rx;
`endif

  assign done = (os_cnt == 4'd0);

  always_ff @(posedge clk_rx or posedge rst_clk_rx) begin
    if (rst_clk_rx) begin
      state       <= IDLE;
      os_cnt      <= 4'd0;
      bit_cnt     <= 3'd0;
      shreg       <= 8'h00;
      rx_data     <= 8'h00;
      rx_data_rdy <= 1'b0;
      frm_err     <= 1'b0;
    end else begin
      rx_data_rdy <= 1'b0;
      frm_err     <= 1'b0;
      if (baud_x16_en) begin
        // later loads in the case below override this decrement
        if (!done) begin
          os_cnt <= os_cnt - 4'd1;
        end
        unique case (state)
          IDLE: begin
            if (!sample) begin
              state  <= START;
              os_cnt <= 4'd7;
            end
          end
          START: begin
            if (done) begin
              if (!sample) begin
                state   <= DATA;
                bit_cnt <= 3'd0;
                os_cnt  <= 4'd15;
              end else begin
                state <= IDLE;
              end
            end
          end
          DATA: begin
            if (done) begin
              shreg[bit_cnt] <= sample;
              os_cnt         <= 4'd15;
              if (bit_cnt == 3'd7) begin
                state <= STOP;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
          STOP: begin
            if (done) begin
              state <= IDLE;
              if (sample) begin
                rx_data     <= shreg;
                rx_data_rdy <= 1'b1;
              end else begin
                frm_err <= 1'b1;
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: doc/uart_rx_ctl.md
UART_RX_CTL -- requirements
Module: uart_rx_ctl

Interface
REQ-001 The block SHALL have one clock and one reset: clk_rx is the only clock, and rst_clk_rx is asynchronous and active-high.
REQ-002 Port clk_rx: input, 1 bit, receive clock.
REQ-003 Port rst_clk_rx: input, 1 bit, asynchronous active-high reset.
REQ-004 Port baud_x16_en: input, 1 bit, 16x oversample enable, one clk_rx cycle wide.
REQ-005 Port rxd_clk_rx: input, 1 bit, serial data, already synchronized to clk_rx; idle level 1.
REQ-006 Port rx_data: output, 8 bits, last received character.
REQ-007 Port rx_data_rdy: output, 1 bit, one-cycle pulse meaning rx_data has been updated.
REQ-008 Port frm_err: output, 1 bit, one-cycle pulse meaning a stop bit was sampled as 0.

Function
REQ-009 The frame format SHALL be 1 start bit (0), 8 data bits LSB first, and 1 stop bit (1), each bit lasting 16 baud_x16_en ticks.
REQ-010 All state, counters and sampling SHALL advance only on clk_rx edges where baud_x16_en=1 (a "tick"); between ticks they hold.
REQ-011 The FSM SHALL have four states: IDLE, START, DATA and STOP.
REQ-012 In IDLE, a tick with sample=0 SHALL move the FSM to START and load the oversample counter with 7.
REQ-013 The 4-bit oversample counter SHALL decrement on each tick while nonzero; "done" means counter==0 at a tick, so a load of N means done N+1 ticks later.
REQ-014 In START, when done: if sample=0, the FSM SHALL go to DATA, clear bit_cnt and load the counter with 15; if sample=1 (false start), it SHALL return to IDLE with no output pulse.
REQ-015 In DATA, when done, the block SHALL:
- write sample into the internal shift register at bit position bit_cnt;
- if bit_cnt=7, go to STOP, else increment bit_cnt;
- load the counter with 15 in both cases.
REQ-016 bit_cnt SHALL be 3 bits; the increment from 7 is never taken, because the FSM leaves DATA at bit_cnt=7.
REQ-017 In STOP, when done: if sample=1, rx_data SHALL be loaded from the shift register and rx_data_rdy pulsed; if sample=0, frm_err SHALL pulse and rx_data SHALL be unchanged. In both cases the FSM SHALL go to IDLE.
REQ-018 rx_data_rdy and frm_err SHALL each be high for exactly one clk_rx cycle: the cycle after the STOP done tick. They SHALL never assert together.
REQ-019 rx_data SHALL change only in the cycle rx_data_rdy asserts, and hold between frames.
REQ-020 Latency from a tick observing the start edge (t0) SHALL be:
- mid-start check at t0+8;
- data bit k sampled at t0+24+16k;
- stop sampled at t0+152;
- pulse one clk_rx cycle after that tick.
REQ-021 After a STOP-to-IDLE transition with the line already low, IDLE SHALL treat the next tick as a new start edge (back-to-back frames and break conditions produce repeated frm_err).

Reset
REQ-022 On rst_clk_rx=1, asynchronously: state=IDLE, counter=0, bit_cnt=0, shift register=0x00, rx_data=0x00, rx_data_rdy=0, frm_err=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame with no output pulse.
REQ-024 After reset deassertion, the first tick SHALL be evaluated from IDLE.

Configuration
REQ-025 The macro UART_RX_MAJORITY_VOTE_EN SHALL select how "sample" is formed.
REQ-026 When UART_RX_MAJORITY_VOTE_EN is defined:
- a 3-bit history register SHALL capture rxd_clk_rx on every tick;
- sample SHALL be the majority of the current rxd_clk_rx and the two previous ticked values;
- the history SHALL reset to 3'b111.
REQ-027 When UART_RX_MAJORITY_VOTE_EN is undefined, sample SHALL equal rxd_clk_rx at the tick, with no history register. Timing per REQ-020 is identical in both builds.

Verification
REQ-028 Reset, then frame 0xA5 with stop=1 -> rx_data=0xA5, rx_data_rdy pulses once at t0+152 ticks+1 cycle, frm_err stays 0.
REQ-029 Two frames back-to-back (0x00 then 0xFF, no idle gap) -> two rdy pulses 160 ticks apart, rx_data=0x00 then 0xFF.
REQ-030 Low glitch of 4 ticks on an idle line -> FSM returns to IDLE at t0+8, no rdy and no frm_err.
REQ-031 Frame 0x3C with stop bit=0 -> frm_err pulses once, rx_data keeps its previous value (0x00 after reset), no rdy.
REQ-032 Reset asserted at data bit 4 of a frame, then a frame 0x81 -> only the 0x81 frame reported.
REQ-033 With UART_RX_MAJORITY_VOTE_EN defined, frame 0x55 with a 1-tick inverted glitch at every sampling tick -> rx_data=0x55; without the macro -> corrupted data or frm_err.
